// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - RV32I next-PC predictor; BHT counters when BRANCH_PREDICTOR_BHT_EN is defined, static BTFN otherwise
module branch_predictor #(
    parameter int BHT_IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr_raw,
    input  logic [31:0] current_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        is_jump_predicted,
    output logic [31:0] next_pc
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic        is_jal;
    logic        is_branch;
    logic        br_taken;

    // Both opcodes end in 2'b11, so compressed/invalid words never decode as control.
    assign imm_j = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12],
                    instr_raw[20], instr_raw[30:21], 1'b0};
    assign imm_b = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7],
                    instr_raw[30:25], instr_raw[11:8], 1'b0};
    assign is_jal    = (instr_raw[6:0] == OP_JAL);
    assign is_branch = (instr_raw[6:0] == OP_BRANCH);

`ifdef BRANCH_PREDICTOR_BHT_EN
    localparam int ENTRIES = 1 << BHT_IDX_BITS;

    logic [1:0]              bht [ENTRIES];
    logic [BHT_IDX_BITS-1:0] rd_idx;
    logic [BHT_IDX_BITS-1:0] wr_idx;
    logic                    unused_upd_pc;

    assign rd_idx = current_pc[BHT_IDX_BITS+1:2];
    assign wr_idx = upd_pc[BHT_IDX_BITS+1:2];
    assign unused_upd_pc = &{1'b0, upd_pc[31:BHT_IDX_BITS+2], upd_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < ENTRIES; k++) begin
                bht[k] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (bht[wr_idx] != 2'b11) begin
                    bht[wr_idx] <= bht[wr_idx] + 2'b01;
                end
            end else if (bht[wr_idx] != 2'b00) begin
                bht[wr_idx] <= bht[wr_idx] - 2'b01;
            end
        end
    end

    // Combinational read sees the pre-edge counter, giving read-before-write.
    assign br_taken = bht[rd_idx][1];
`else
    logic unused_ports;

    assign unused_ports = &{1'b0, clk, rstn, upd_valid, upd_pc, upd_taken};
    assign br_taken     = instr_raw[31];
`endif

    always_comb begin
        is_jump_predicted = 1'b0;
        next_pc           = current_pc + 32'd4;
        if (is_jal) begin
            is_jump_predicted = 1'b1;
            next_pc           = current_pc + imm_j;
        end else if (is_branch && br_taken) begin
            is_jump_predicted = 1'b1;
            next_pc           = current_pc + imm_b;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and model-compared bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instr_raw;
    logic [31:0] current_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        is_jump_predicted;
    logic [31:0] next_pc;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;
    int cnt [64];

    always #5 clk = ~clk;

    branch_predictor #(.BHT_IDX_BITS(6)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .instr_raw         (instr_raw),
        .current_pc        (current_pc),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .is_jump_predicted (is_jump_predicted),
        .next_pc           (next_pc)
    );

    // Reference model: counters as plain integers 0..3, indexed by word address mod 64.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < 64; k++) cnt[k] = 1;
        end else if (upd_valid) begin
            int ix;
            ix = int'((upd_pc >> 2) % 64);
            if (upd_taken) cnt[ix] = (cnt[ix] >= 3) ? 3 : cnt[ix] + 1;
            else           cnt[ix] = (cnt[ix] <= 0) ? 0 : cnt[ix] - 1;
        end
    end

    function automatic void predict(input logic [31:0] i, input logic [31:0] pc,
                                    output logic j, output logic [31:0] npc);
        int off;
        bit take;
        j   = 1'b0;
        npc = pc + 32'd4;
        if (i[6:0] == 7'h6F) begin
            off = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            j   = 1'b1;
            npc = pc + off;
        end else if (i[6:0] == 7'h63) begin
            off = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
`ifdef BRANCH_PREDICTOR_BHT_EN
            take = cnt[int'((pc >> 2) % 64)] >= 2;
`else
            take = (off < 0);
`endif
            if (take) begin
                j   = 1'b1;
                npc = pc + off;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic        ej;
            logic [31:0] en;
            predict(instr_raw, current_pc, ej, en);
            total++;
            if (is_jump_predicted === ej && next_pc === en) passed++;
            else $display("FAIL model pc=%h instr=%h: got %b/%h expected %b/%h",
                          current_pc, instr_raw, is_jump_predicted, next_pc, ej, en);
        end
    end

    task automatic drive(input logic r, input logic [31:0] i, input logic [31:0] pc,
                         input logic uv, input logic [31:0] up, input logic ut);
        @(posedge clk);
        #1;
        rstn = r; instr_raw = i; current_pc = pc;
        upd_valid = uv; upd_pc = up; upd_taken = ut;
    endtask

    task automatic expect_out(input string name, input logic ej, input logic [31:0] en);
        @(negedge clk);
        #1;
        total++;
        if (is_jump_predicted === ej && next_pc === en) passed++;
        else $display("FAIL %s: got %b/%h expected %b/%h", name, is_jump_predicted, next_pc, ej, en);
    endtask

    localparam logic [31:0] BEQ_BACK = 32'hFE000EE3;
    localparam logic [31:0] BEQ_FWD  = 32'h00000463;

    initial begin
        logic [31:0] tbl [6];
        tbl[0] = 32'h0080006F; tbl[1] = BEQ_BACK; tbl[2] = BEQ_FWD;
        tbl[3] = 32'h00000013; tbl[4] = 32'h00008067; tbl[5] = 32'h0080006D;

        rstn = 1'b0; instr_raw = 32'h13; current_pc = 32'h0;
        upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
        drive(0, 32'h13, 32'h0, 1, 32'h200, 1);
        drive(0, 32'h13, 32'h0, 1, 32'h200, 1);
        chk_en = 1'b1;

        drive(1, 32'h0080006F, 32'h100, 0, 0, 0);
        expect_out("jal", 1'b1, 32'h108);

        drive(1, BEQ_BACK, 32'h200, 0, 0, 0);
`ifdef BRANCH_PREDICTOR_BHT_EN
        expect_out("branch_after_reset", 1'b0, 32'h204);
`else
        expect_out("static_backward", 1'b1, 32'h1FC);
`endif

        drive(1, BEQ_BACK, 32'h200, 1, 32'h200, 1);
        drive(1, BEQ_BACK, 32'h200, 0, 0, 0);
        expect_out("train_taken", 1'b1, 32'h1FC);

        for (int k = 0; k < 3; k++) drive(1, BEQ_BACK, 32'h200, 1, 32'h200, 0);
        drive(1, BEQ_BACK, 32'h200, 0, 0, 0);
`ifdef BRANCH_PREDICTOR_BHT_EN
        expect_out("train_not_taken", 1'b0, 32'h204);
`else
        expect_out("static_ignores_upd", 1'b1, 32'h1FC);
`endif

        // One taken step from a saturated 00 lands on 01, still not taken.
        drive(1, BEQ_BACK, 32'h200, 1, 32'h200, 1);
        drive(1, BEQ_BACK, 32'h200, 0, 0, 0);
`ifdef BRANCH_PREDICTOR_BHT_EN
        expect_out("saturate_low", 1'b0, 32'h204);
`else
        expect_out("static_backward_2", 1'b1, 32'h1FC);
`endif

        drive(1, BEQ_FWD, 32'h200, 0, 0, 0);
        expect_out("forward_branch", 1'b0, 32'h204);

        drive(1, 32'h00000013, 32'hFFFFFFFC, 0, 0, 0);
        expect_out("wrap_addi", 1'b0, 32'h0);

        drive(1, 32'h00008067, 32'h300, 0, 0, 0);
        expect_out("jalr", 1'b0, 32'h304);

        drive(1, 32'h0080006D, 32'h400, 0, 0, 0);
        expect_out("low_bits_not_11", 1'b0, 32'h404);

        // Counter now 01: lookup during a taken update still sees 01.
        drive(1, BEQ_BACK, 32'h200, 1, 32'h200, 1);
`ifdef BRANCH_PREDICTOR_BHT_EN
        expect_out("read_before_write", 1'b0, 32'h204);
`else
        expect_out("static_rbw", 1'b1, 32'h1FC);
`endif
        drive(1, BEQ_BACK, 32'h200, 0, 0, 0);
        expect_out("after_write", 1'b1, 32'h1FC);

        drive(0, BEQ_BACK, 32'h200, 1, 32'h200, 1);
        drive(1, BEQ_BACK, 32'h200, 0, 0, 0);
`ifdef BRANCH_PREDICTOR_BHT_EN
        expect_out("reset_priority", 1'b0, 32'h204);
`else
        expect_out("static_after_reset", 1'b1, 32'h1FC);
`endif

        // 0x300 aliases 0x200 in a 64-entry table.
        drive(1, BEQ_BACK, 32'h200, 1, 32'h300, 1);
        drive(1, BEQ_BACK, 32'h200, 0, 0, 0);
        expect_out("alias", 1'b1, 32'h1FC);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] pc;
            logic [31:0] up;
            pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            if ($urandom_range(0, 1) == 1) pc = {22'h0, $urandom_range(0, 15), 6'h0} & 32'h3FC;
            up = {$urandom_range(0, 1023), 2'b00};
            drive(($urandom_range(0, 40) != 0), tbl[$urandom_range(0, 5)], pc,
                  ($urandom_range(0, 2) != 0), up, $urandom_range(0, 1) == 1);
        end

        drive(1, 32'h13, 32'h0, 0, 0, 0);
        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
